// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead add/subtract unit.
package cla_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam int unsigned MaxWidth = 128;

  // Largest positive signed value for the given width (0 followed by ones).
  function automatic logic [MaxWidth-1:0] sat_max(input int unsigned width);
    return (MaxWidth'(1) << (width - 1)) - MaxWidth'(1);
  endfunction

  // Most negative signed value for the given width (1 followed by zeros).
  function automatic logic [MaxWidth-1:0] sat_min(input int unsigned width);
    return MaxWidth'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational lookahead block: per-bit carries expanded from generate/propagate,
// plus group propagate/generate for the inter-group carry chain.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             p,
  output logic             g,
  output logic             cout
);

  logic [GROUP-1:0] bp;
  logic [GROUP-1:0] bg;
  logic [GROUP:0]   c;
  logic             acc;
  logic             pp;

  always_comb begin
    bp   = a ^ b;
    bg   = a & b;
    c    = '0;
    c[0] = cin;
    acc  = 1'b0;
    pp   = 1'b1;
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built without rippling through c[]
    for (int i = 0; i < int'(GROUP); i++) begin
      acc = bg[i];
      pp  = bp[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & bg[j]);
        pp  = pp & bp[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    // After the last iteration acc/pp hold the whole-group generate/propagate.
    g    = acc;
    p    = pp;
    cout = c[GROUP];
    sum  = bp ^ c[GROUP-1:0];
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage elastic add/subtract: low half summed in stage 1, high half, saturation and
// N/Z/V/C flags in stage 2. Valid/ready handshake with full throughput.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned NG = HW / GROUP;
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));

  // Stage 1 datapath: low half with carry-in = sub.
  logic [WIDTH-1:0] b_eff;
  logic [HW-1:0]    lo_sum;
  logic [NG-1:0]    lo_p, lo_g, lo_cout;
  logic [NG:0]      lo_c;

  assign b_eff   = sub ? ~b : b;
  assign lo_c[0] = sub;

  for (genvar gi = 0; gi < int'(NG); gi++) begin : g_lo
    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (a[gi*GROUP +: GROUP]),
      .b    (b_eff[gi*GROUP +: GROUP]),
      .cin  (lo_c[gi]),
      .sum  (lo_sum[gi*GROUP +: GROUP]),
      .p    (lo_p[gi]),
      .g    (lo_g[gi]),
      .cout (lo_cout[gi])
    );
    assign lo_c[gi+1] = lo_g[gi] | (lo_p[gi] & lo_c[gi]);
  end

  logic          s1_valid_q, s1_valid_d;
  logic [HW-1:0] s1_lo_q, s1_lo_d;
  logic          s1_c_q, s1_c_d;
  logic [HW-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [HW-1:0] s1_b_hi_q, s1_b_hi_d;
  logic          s1_sat_q, s1_sat_d;

  // Stage 2 datapath: high half from registered operands and low-half carry.
  logic [HW-1:0]    hi_sum;
  logic [NG-1:0]    hi_p, hi_g, hi_cout;
  logic [NG:0]      hi_c;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic [3:0]       res_flags;

  assign hi_c[0] = s1_c_q;

  for (genvar gi = 0; gi < int'(NG); gi++) begin : g_hi
    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (s1_a_hi_q[gi*GROUP +: GROUP]),
      .b    (s1_b_hi_q[gi*GROUP +: GROUP]),
      .cin  (hi_c[gi]),
      .sum  (hi_sum[gi*GROUP +: GROUP]),
      .p    (hi_p[gi]),
      .g    (hi_g[gi]),
      .cout (hi_cout[gi])
    );
    assign hi_c[gi+1] = hi_g[gi] | (hi_p[gi] & hi_c[gi]);
  end

  // The chain uses group p/g; the per-group couts are redundant copies of the same carries.
  logic unused_cout;
  assign unused_cout = ^{lo_cout, hi_cout};

  always_comb begin
    raw = {hi_sum, s1_lo_q};
    ovf = (s1_a_hi_q[HW-1] == s1_b_hi_q[HW-1]) & (raw[WIDTH-1] != s1_a_hi_q[HW-1]);
    res = raw;
    if (s1_sat_q && ovf) begin
      res = s1_a_hi_q[HW-1] ? SatMin : SatMax;
    end
    res_flags         = '0;
    res_flags[FLAG_N] = res[WIDTH-1];
    res_flags[FLAG_Z] = (res == '0);
    res_flags[FLAG_V] = ovf;
    res_flags[FLAG_C] = hi_c[NG];
  end

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [3:0]       flags_q, flags_d;
  logic             s2_adv;
  logic             accept;

  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    in_ready = ~rst & (~s1_valid_q | s2_adv);
    accept   = in_valid & in_ready;

    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c_d     = s1_c_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_b_hi_d  = s1_b_hi_q;
    s1_sat_d   = s1_sat_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    flags_d    = flags_q;

    if (~s1_valid_q | s2_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_lo_d   = lo_sum;
      s1_c_d    = lo_c[NG];
      s1_a_hi_d = a[WIDTH-1:HW];
      s1_b_hi_d = b_eff[WIDTH-1:HW];
      s1_sat_d  = sat;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d   = res;
        flags_d = res_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_a_hi_q  <= '0;
      s1_b_hi_q  <= '0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c_q     <= s1_c_d;
      s1_a_hi_q  <= s1_a_hi_d;
      s1_b_hi_q  <= s1_b_hi_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign flags     = flags_q;

endmodule
